// File: rtl/alu_pkg.sv
// Shared types for the ALU issue stage: op-select encodings and the command record.
package alu_pkg;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_OR   = 2'b10;
    localparam logic [1:0] ALU_NAND = 2'b11;

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic [1:0] sel;
    } alu_cmd_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Command FIFO for the ALU issue stage; full/empty derived from an occupancy count.
module alu_cmd_fifo
    import alu_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  alu_cmd_t      wdata,
    output alu_cmd_t      head,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    alu_cmd_t      mem_q [DEPTH];

    // Pointers are exactly AW bits wide, so wrap modulo DEPTH comes for free.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the head is masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wdata;
    end

    assign count = count_q;
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign head  = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/alu_issue.sv
// Issue stage around an external combinational 4-bit ALU: buffers commands,
// drives the FIFO head onto the ALU and registers its result for a consumer.
module alu_issue
    import alu_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3:0]    in_a,
    input  logic [3:0]    in_b,
    input  logic [1:0]    in_sel,
    output logic [3:0]    alu_a,
    output logic [3:0]    alu_b,
    output logic [1:0]    alu_sel,
    input  logic [3:0]    alu_out,
    input  logic          alu_c,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [3:0]    res_data,
    output logic          res_c,
    output logic [1:0]    res_sel,
    output logic [CW-1:0] count
);

    alu_cmd_t   in_cmd, head;
    logic       full, empty, push, pop;
    logic       res_valid_q, res_valid_d;
    logic [3:0] res_data_q, res_data_d;
    logic       res_c_q, res_c_d;
    logic [1:0] res_sel_q, res_sel_d;

    assign in_cmd   = '{a: in_a, b: in_b, sel: in_sel};
    // in_ready ignores a same-cycle pop to keep it off the consumer's ready path.
    assign in_ready = !full;
    assign push     = in_valid && !full;
    assign pop      = !empty && (!res_valid_q || res_ready);

    alu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (in_cmd),
        .head  (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    assign alu_a   = head.a;
    assign alu_b   = head.b;
    assign alu_sel = head.sel;

    always_comb begin
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_c_d     = res_c_q;
        res_sel_d   = res_sel_q;
        if (pop) begin
            res_valid_d = 1'b1;
            res_data_d  = alu_out;
            res_c_d     = alu_c;
            res_sel_d   = head.sel;
        end else if (res_valid_q && res_ready) begin
            res_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_c_q     <= 1'b0;
            res_sel_q   <= '0;
        end else begin
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_c_q     <= res_c_d;
            res_sel_q   <= res_sel_d;
        end
    end

    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_c     = res_c_q;
    assign res_sel   = res_sel_q;

endmodule

// File: doc/alu_issue.md
# alu_issue

Command-issue stage that sits directly upstream of the 4-bit combinational ALU, and also captures its result. It buffers (A, B, op-select) commands from a valid/ready producer in a small FIFO and drives the FIFO head onto the ALU operand/select inputs. It registers the ALU result and carry into an output register and presents them to a valid/ready consumer. This gives the combinational ALU a pipelined, back-pressurable interface.

## Interface
- DEPTH, 4, command FIFO entries; power of two, ≥2
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  command offered
- in_ready  out  1  command accepted when in_valid & in_ready at posedge
- in_a  in  4  operand A
- in_b  in  4  operand B
- in_sel  in  2  op: 00 add, 01 sub, 10 or, 11 nand
- alu_a  out  4  to ALU A; FIFO head A, 0 when FIFO empty
- alu_b  out  4  to ALU B; FIFO head B, 0 when empty
- alu_sel  out  2  to ALU select; FIFO head sel, 0 when empty
- alu_out  in  4  ALU result (combinational from alu_*)
- alu_c  in  1  ALU carry (carry of A+B regardless of sel; passed through unmodified)
- res_valid  out  1  result register holds unconsumed result
- res_ready  in  1  consumer accepts when res_valid & res_ready at posedge
- res_data  out  4  registered alu_out
- res_c  out  1  registered alu_c
- res_sel  out  2  op-select that produced res_data (tag)
- count  out  $clog2(DEPTH)+1  FIFO occupancy, excludes result register

## Operation
- push = in_valid & in_ready; in_ready = (count < DEPTH), independent of same-cycle pop.
- pop = (count != 0) & (!res_valid | res_ready).
- On pop: res_data ← alu_out, res_c ← alu_c, res_sel ← head sel, res_valid ← 1; read pointer advances.
- If res_valid & res_ready & no pop: res_valid ← 0. res_data, res_c and res_sel hold their last values.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- Pointers wrap modulo DEPTH. Full = count==DEPTH and empty = count==0, both derived from count.
- alu_* are combinational from the head entry. They are forced to 0 when empty so the ALU input is deterministic.
- No reordering and no dropping: results leave in command order. Push while full cannot occur, because in_ready is low.
- Arithmetic is the ALU's own, 4-bit modulo. This block performs no arithmetic.

## Timing
- Reset values: in_ready 1; count 0; pointers 0; res_valid 0; res_data 0; res_c 0; res_sel 0; alu_a/alu_b/alu_sel 0.
- rst asserted mid-operation discards all buffered commands and any pending result at that edge. No result is emitted afterward.
- Latency: a command pushed at edge N into an empty FIFO with a free result register appears on alu_* after N. res_valid is high after edge N+1, so latency is 2 cycles.
- Throughput: 1 result/cycle with res_ready held high and in_valid continuous.
- Capacity: DEPTH commands in the FIFO plus 1 in the result register, i.e. DEPTH+1 outstanding.
- With res_ready low: res_valid and res_data/res_c/res_sel are stable, and no pop occurs.
- The ALU combinational path (head → alu_* → alu_out → res_data D-input) must close in one cycle.

## Structure
- Package alu_pkg holds:
  - The op-select constants ALU_ADD=2'b00, ALU_SUB=2'b01, ALU_OR=2'b10, ALU_NAND=2'b11.
  - A packed command struct alu_cmd_t {a[3:0], b[3:0], sel[1:0]}.
- Sub-module alu_cmd_fifo (DEPTH-parameterised, alu_cmd_t storage, push/pop/count/head) is instantiated once.
- The result register and pop logic live in alu_issue.
- The ALU is instantiated outside this block by the parent.

## Test plan
- Reset, idle: after reset with no traffic, in_ready=1, count=0, res_valid=0, and alu_a/alu_b/alu_sel=0.
- Add with carry: push A=9, B=8, sel=00, res_ready=1 → 2 cycles later res_valid=1, res_data=4'h1, res_c=1, res_sel=00.
- Sub and NAND: push (3,5,01) then (F,F,11) back-to-back → results 4'hE/c=0, then 4'h0/c=1, on consecutive cycles.
- Backpressure/full (DEPTH=4): res_ready=0, push 6 commands → 5 accepted, then in_ready=0 with count=4. res_data holds the first result. Raising res_ready drains all 5 in order, one per cycle.
- Simultaneous push/pop at count=2 with res_ready=1 → count stays 2 and ordering is preserved.
- Mid-stream reset: assert rst for one cycle with count=3 and res_valid=1 → next cycle count=0, res_valid=0, in_ready=1, and no stale result appears afterward.
